// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed HH:MM scan controller driving one shared
// BCD-to-seven-segment decoder, with inter-digit blanking, leading hour-tens
// zero suppression and frame-aligned (tear-free) display snapshots.
module seg_scan_ctrl #(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       upd,
    input  logic [7:0] hh_bcd,
    input  logic [7:0] mm_bcd,
    input  logic       pm,
    input  logic [6:0] seg_in,
    output logic [3:0] bcd_sel,
    output logic [6:0] seg_out,
    output logic [3:0] digit_en,
    output logic       dp,
    output logic       frame_tick
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LOAD = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
    localparam logic [3:0]    BCD_OFF    = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        DWELL,
        BLANK
    } state_t;

    state_t        state, state_nx;
    logic [1:0]    idx, idx_nx;
    logic [CW-1:0] cnt, cnt_nx;
    // {hh[7:0], mm[7:0], pm}
    logic [16:0]   shadow, shadow_nx;
    logic [16:0]   snapshot, snapshot_nx;
    logic          pending, pending_nx;
    logic          advance;
    logic          tick_nx;
    logic [3:0]    nibble;
    logic [3:0]    digit_en_nx, bcd_sel_nx;
    logic          dp_nx;

    // Scan sequencing plus shadow/snapshot bookkeeping for the coming cycle.
    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        cnt_nx      = cnt;
        shadow_nx   = shadow;
        snapshot_nx = snapshot;
        pending_nx  = pending;
        advance     = 1'b0;
        tick_nx     = 1'b0;

        if (upd) begin
            shadow_nx = {hh_bcd, mm_bcd, pm};
        end

        if (!en) begin
            state_nx = IDLE;
            idx_nx   = 2'd0;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = DWELL;
                    idx_nx   = 2'd0;
                    cnt_nx   = DWELL_LOAD;
                end
                DWELL: begin
                    if (cnt == '0) begin
                        if (BLANK_CYCLES > 0) begin
                            state_nx = BLANK;
                            cnt_nx   = BLANK_LOAD;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        cnt_nx = cnt - CW'(1);
                    end
                end
                BLANK: begin
                    if (cnt == '0) begin
                        advance = 1'b1;
                    end else begin
                        cnt_nx = cnt - CW'(1);
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end

        if (advance) begin
            state_nx = DWELL;
            idx_nx   = idx + 2'd1;
            cnt_nx   = DWELL_LOAD;
            tick_nx  = (idx == 2'd3);
        end

        // The snapshot uses the shadow as it stood before this cycle's upd,
        // so an upd landing on a boundary stays pending for the next frame.
        if (pending && (tick_nx || state == IDLE)) begin
            snapshot_nx = shadow;
            pending_nx  = 1'b0;
        end
        if (upd) begin
            pending_nx = 1'b1;
        end
    end

    // Registered decoder drive derived from the next state and next snapshot.
    always_comb begin
        digit_en_nx = 4'b0000;
        bcd_sel_nx  = BCD_OFF;
        dp_nx       = 1'b0;
        case (idx_nx)
            2'd0:    nibble = snapshot_nx[16:13];
            2'd1:    nibble = snapshot_nx[12:9];
            2'd2:    nibble = snapshot_nx[8:5];
            default: nibble = snapshot_nx[4:1];
        endcase
        if (state_nx == DWELL) begin
            digit_en_nx = 4'b0001 << idx_nx;
            bcd_sel_nx  = (idx_nx == 2'd0 && nibble == 4'd0) ? BCD_OFF : nibble;
            dp_nx       = (idx_nx == 2'd1) && snapshot_nx[0];
        end
    end

    // State, snapshot and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 2'd0;
            cnt        <= '0;
            shadow     <= '0;
            snapshot   <= '0;
            pending    <= 1'b0;
            digit_en   <= 4'b0000;
            bcd_sel    <= BCD_OFF;
            dp         <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            cnt        <= cnt_nx;
            shadow     <= shadow_nx;
            snapshot   <= snapshot_nx;
            pending    <= pending_nx;
            digit_en   <= digit_en_nx;
            bcd_sel    <= bcd_sel_nx;
            dp         <= dp_nx;
            frame_tick <= tick_nx;
        end
    end

    // Pass decoder segments only while a real digit is lit.
    always_comb begin
        seg_out = 7'h00;
        if (digit_en != 4'b0000 && bcd_sel != BCD_OFF) begin
            seg_out = seg_in;
        end
    end

endmodule
